// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the state-RAM port arbiter
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    localparam int SRAM_ARB_ADDR_W = 8;
    localparam int SRAM_ARB_DATA_W = 8;

    localparam int REQ_INIT = 0;
    localparam int REQ_SHUF = 1;
    localparam int REQ_HOST = 2;

endpackage

// File: rtl/sram_port_arbiter_arb_pick.sv
// rtl/sram_port_arbiter_arb_pick.sv - combinational one-hot winner search over pending requests
module arb_pick #(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_excl,
    input  logic [PTR_W-1:0] i_start,
    output logic [N_REQ-1:0] o_gnt,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_any
);

    logic [N_REQ-1:0] w_cand;
    logic [PTR_W-1:0] w_pos;

    assign w_cand = i_req & ~i_excl;

    // Circular scan from i_start; the first pending candidate wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_pos = PTR_W'((int'(i_start) + k) % N_REQ);
            if (!o_any && w_cand[w_pos]) begin
                o_any        = 1'b1;
                o_idx        = w_pos;
                o_gnt[w_pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - req/gnt arbiter that owns the single state-RAM port
// Optional: SRAM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int ADDR_W   = SRAM_ARB_ADDR_W,
    parameter int DATA_W   = SRAM_ARB_DATA_W,
    parameter int MAX_HOLD = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_wrdata,
    input  logic [N_REQ-1:0]         req_wren,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wrdata,
    output logic                     mem_wren,
    input  logic [DATA_W-1:0]        mem_rddata,
    output logic [DATA_W-1:0]        rd_data,
    output logic [N_REQ-1:0]         rd_valid
);

    localparam int PTR_W  = $clog2(N_REQ);
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    arb_state_t        r_state, w_state_nxt;
    logic [N_REQ-1:0]  r_gnt, w_gnt_nxt;
    logic [PTR_W-1:0]  r_owner, w_owner_nxt;
    logic [N_REQ-1:0]  r_rd_valid, w_rd_valid_nxt;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;

    logic              w_access;
    logic              w_others;
    logic              w_revoke;
    logic [N_REQ-1:0]  w_owner_oh;
    logic [N_REQ-1:0]  w_excl;
    logic [PTR_W-1:0]  w_start;
    logic [N_REQ-1:0]  w_pick_gnt;
    logic [PTR_W-1:0]  w_pick_idx;
    logic              w_pick_any;

    // r_owner survives the release so a late read still finds its way home during TURN.
    assign w_owner_oh = N_REQ'(1) << r_owner;
    assign w_access   = (r_state == GRANT) && req[r_owner];
    assign w_others   = |(req & ~w_owner_oh);
    assign w_revoke   = (MAX_HOLD != 0) && w_others && (r_hold_cnt >= HOLD_LAST);
    assign w_excl     = ((r_state == TURN) && w_others) ? w_owner_oh : '0;

    arb_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_req   (req),
        .i_excl  (w_excl),
        .i_start (w_start),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] r_rr_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if ((r_state != GRANT) && w_pick_any) begin
            r_rr_ptr <= (w_pick_idx == PTR_W'(N_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
        end
    end

    assign w_start = r_rr_ptr;
`else
    assign w_start = '0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_owner_nxt    = r_owner;
        w_hold_nxt     = r_hold_cnt;
        w_rd_valid_nxt = (w_access && !req_wren[r_owner]) ? w_owner_oh : '0;
        case (r_state)
            IDLE, TURN: begin
                if (w_pick_any) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = w_pick_gnt;
                    w_owner_nxt = w_pick_idx;
                    w_hold_nxt  = '0;
                end else begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                end
            end
            GRANT: begin
                w_hold_nxt = (r_hold_cnt == HOLD_MAX) ? r_hold_cnt : r_hold_cnt + 1'b1;
                if (!req[r_owner] || w_revoke) begin
                    w_state_nxt = TURN;
                    w_gnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_owner    <= '0;
            r_rd_valid <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_owner    <= w_owner_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    assign gnt        = r_gnt;
    assign rd_valid   = r_rd_valid;
    assign rd_data    = mem_rddata;
    assign mem_wren   = w_access && req_wren[r_owner];
    assign mem_addr   = (r_state == GRANT) ? req_addr[int'(r_owner) * ADDR_W +: ADDR_W] : '0;
    assign mem_wrdata = (r_state == GRANT) ? req_wrdata[int'(r_owner) * DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench: vector table, directed corners, random vs reference model
module tb_sram_port_arbiter;

    localparam int N  = 3;
    localparam int MH = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   req = '0;
    logic [2:0]   req_wren = '0;
    logic [23:0]  req_addr = '0;
    logic [23:0]  req_wrdata = '0;
    logic [2:0]   gnt;
    logic [2:0]   rd_valid;
    logic [7:0]   mem_addr;
    logic [7:0]   mem_wrdata;
    logic         mem_wren;
    logic [7:0]   mem_rddata;
    logic [7:0]   rd_data;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .N_REQ    (N),
        .ADDR_W   (8),
        .DATA_W   (8),
        .MAX_HOLD (MH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt        (gnt),
        .req_addr   (req_addr),
        .req_wrdata (req_wrdata),
        .req_wren   (req_wren),
        .mem_addr   (mem_addr),
        .mem_wrdata (mem_wrdata),
        .mem_wren   (mem_wren),
        .mem_rddata (mem_rddata),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid)
    );

    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
            mem_rddata <= 8'h00;
        end else begin
            if (mem_wren) ram[mem_addr] <= mem_wrdata;
            mem_rddata <= ram[mem_addr];
        end
    end

    int checks = 0;
    int failures = 0;

    logic [2:0] s_gnt, s_rdv;
    logic       s_wr;
    logic [7:0] s_addr, s_wd, s_rdd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        s_gnt  = gnt;
        s_rdv  = rd_valid;
        s_wr   = mem_wren;
        s_addr = mem_addr;
        s_wd   = mem_wrdata;
        s_rdd  = rd_data;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [2:0] r, input logic [2:0] w);
        req      = r;
        req_wren = w;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_addr   = {8'h12, 8'h11, 8'h10};
        req_wrdata = {8'hA2, 8'hA1, 8'hA0};
        set_in(3'b111, 3'b111);
        cyc();
        cyc();
        rst_n = 1'b1;
        set_in(3'b000, 3'b000);
    endtask

    function automatic logic [7:0] addr_of(input logic [2:0] g);
        case (g)
            3'b001:  return 8'h10;
            3'b010:  return 8'h11;
            3'b100:  return 8'h12;
            default: return 8'h00;
        endcase
    endfunction

    typedef struct packed {
        logic [2:0] req;
        logic [2:0] wren;
        logic [2:0] gnt;
        logic       wr;
        logic [2:0] rdv;
        logic [7:0] rdd;
    } vec_t;
    vec_t tbl [23];

    // Behavioural reference: owner index (-1 = none), dead-cycle flag, hold count, shadow RAM.
    int         m_own, m_last, m_hold, m_rr;
    bit         m_turn;
    logic [2:0] m_rdv;
    logic [7:0] m_rdd;
    logic [7:0] mm [256];

    function automatic int pick(input logic [2:0] cand, input int start);
        for (int k = 0; k < N; k++) begin
            if (cand[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int         n, pulses, o, w;
        bit         granted, acc;
        logic [2:0] e_gnt, others, cand, keep;
        logic       e_wr;
        logic [7:0] e_addr, e_wd;

        tbl[0]  = '{3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00};
        tbl[1]  = '{3'b111, 3'b111, 3'b000, 1'b0, 3'b000, 8'h00};
        tbl[2]  = '{3'b111, 3'b111, 3'b001, 1'b1, 3'b000, 8'h00};
        tbl[3]  = '{3'b111, 3'b110, 3'b001, 1'b0, 3'b000, 8'h00};
        tbl[4]  = '{3'b110, 3'b110, 3'b001, 1'b0, 3'b001, 8'hA0};
        tbl[5]  = '{3'b111, 3'b110, 3'b000, 1'b0, 3'b000, 8'h00};
        tbl[6]  = '{3'b111, 3'b100, 3'b010, 1'b0, 3'b000, 8'h00};
        tbl[7]  = '{3'b100, 3'b100, 3'b010, 1'b0, 3'b010, 8'h00};
        tbl[8]  = '{3'b100, 3'b100, 3'b000, 1'b0, 3'b000, 8'h00};
        tbl[9]  = '{3'b100, 3'b100, 3'b100, 1'b1, 3'b000, 8'h00};
        tbl[10] = '{3'b000, 3'b000, 3'b100, 1'b0, 3'b000, 8'h00};
        tbl[11] = '{3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00};
        tbl[12] = '{3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00};
        tbl[13] = '{3'b100, 3'b100, 3'b000, 1'b0, 3'b000, 8'h00};
        tbl[14] = '{3'b000, 3'b100, 3'b100, 1'b0, 3'b000, 8'h00};
        tbl[15] = '{3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00};
        tbl[16] = '{3'b001, 3'b001, 3'b000, 1'b0, 3'b000, 8'h00};
        tbl[17] = '{3'b001, 3'b001, 3'b001, 1'b1, 3'b000, 8'h00};
        tbl[18] = '{3'b101, 3'b101, 3'b001, 1'b1, 3'b000, 8'h00};
        tbl[19] = '{3'b001, 3'b001, 3'b001, 1'b1, 3'b000, 8'h00};
        tbl[20] = '{3'b000, 3'b000, 3'b001, 1'b0, 3'b000, 8'h00};
        tbl[21] = '{3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00};
        tbl[22] = '{3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00};

        // Reset values, sampled while every requester is asking.
        do_reset();
        chk("reset_gnt", 32'(s_gnt), 32'd0);
        chk("reset_rdv", 32'(s_rdv), 32'd0);
        chk("reset_wren", 32'(s_wr), 32'd0);
        chk("reset_addr", 32'(s_addr), 32'd0);
        chk("reset_wrdata", 32'(s_wd), 32'd0);

        // Handover, read return, late req pulse, pulse while another owns.
        for (int i = 0; i < 23; i++) begin
            set_in(tbl[i].req, tbl[i].wren);
            cyc();
            chk($sformatf("vec%0d_gnt", i), 32'(s_gnt), 32'(tbl[i].gnt));
            chk($sformatf("vec%0d_wren", i), 32'(s_wr), 32'(tbl[i].wr));
            chk($sformatf("vec%0d_rdv", i), 32'(s_rdv), 32'(tbl[i].rdv));
            chk($sformatf("vec%0d_addr", i), 32'(s_addr), 32'(addr_of(tbl[i].gnt)));
            if (tbl[i].rdv != 3'b000)
                chk($sformatf("vec%0d_rdata", i), 32'(s_rdd), 32'(tbl[i].rdd));
        end

        // Requester 0 fills 0..255 then reads address 37.
        do_reset();
        set_in(3'b001, 3'b001);
        req_addr[7:0]   = 8'd0;
        req_wrdata[7:0] = 8'd0;
        cyc();
        chk("fill_idle_gnt", 32'(s_gnt), 32'd0);
        pulses = 0;
        for (int k = 0; k < 256; k++) begin
            req_addr[7:0]   = 8'(k);
            req_wrdata[7:0] = 8'(k);
            cyc();
            if (k == 0) chk("fill_grant_latency", 32'(s_gnt), 32'b001);
            if (s_wr) pulses++;
        end
        chk("fill_pulses", 32'(pulses), 32'd256);
        req_addr[7:0] = 8'd37;
        set_in(3'b001, 3'b000);
        cyc();
        set_in(3'b000, 3'b000);
        cyc();
        chk("fill_rd_valid", 32'(s_rdv), 32'b001);
        chk("fill_rd_data", 32'(s_rdd), 32'd37);

        // Hold limit: 1 is revoked after MH cycles, 2 runs, then 1 is re-granted.
        do_reset();
        set_in(3'b110, 3'b000);
        cyc();
        chk("hold_idle_gnt", 32'(s_gnt), 32'd0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (s_gnt == 3'b010) n++;
            else break;
        end
        chk("hold_cycles", 32'(n), 32'(MH));
        chk("hold_turn_gnt", 32'(s_gnt), 32'd0);
        chk("hold_turn_rdv_old_owner", 32'(s_rdv), 32'b010);
        cyc();
        chk("hold_new_owner_gnt", 32'(s_gnt), 32'b100);
        chk("hold_new_owner_no_rdv", 32'(s_rdv), 32'd0);
        set_in(3'b010, 3'b000);
        cyc();
        chk("hold_release_gnt", 32'(s_gnt), 32'b100);
        chk("hold_release_rdv", 32'(s_rdv), 32'b100);
        cyc();
        chk("hold_turn2_gnt", 32'(s_gnt), 32'd0);
        chk("hold_turn2_rdv", 32'(s_rdv), 32'd0);
        cyc();
        chk("hold_regrant", 32'(s_gnt), 32'b010);

        // Reset mid-transaction discards the in-flight read and the grant.
        do_reset();
        set_in(3'b010, 3'b010);
        cyc();
        cyc();
        chk("rst_pre_wren", 32'(s_wr), 32'd1);
        rst_n = 1'b0;
        set_in(3'b010, 3'b000);
        cyc();
        rst_n = 1'b1;
        set_in(3'b010, 3'b010);
        cyc();
        chk("rst_gnt", 32'(s_gnt), 32'd0);
        chk("rst_wren", 32'(s_wr), 32'd0);
        chk("rst_rdv", 32'(s_rdv), 32'd0);
        cyc();
        chk("rst_idle_regrant", 32'(s_gnt), 32'b010);

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 256; i++) mm[i] = 8'h00;
        m_own = -1; m_last = 0; m_hold = 0; m_rr = 0; m_turn = 1'b0;
        m_rdv = '0; m_rdd = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(3) == 0) req[b] = ~req[b];
            req_wren   = 3'($urandom);
            req_addr   = 24'($urandom);
            req_wrdata = 24'($urandom);
            cyc();
            granted = (m_own >= 0);
            o       = granted ? m_own : 0;
            e_gnt   = granted ? 3'(1 << o) : 3'b000;
            acc     = granted && req[o];
            e_wr    = acc && req_wren[o];
            e_addr  = granted ? req_addr[o*8 +: 8] : 8'h00;
            e_wd    = granted ? req_wrdata[o*8 +: 8] : 8'h00;
            chk("rnd_gnt", 32'(s_gnt), 32'(e_gnt));
            chk("rnd_wren", 32'(s_wr), 32'(e_wr));
            chk("rnd_addr", 32'(s_addr), 32'(e_addr));
            chk("rnd_wrdata", 32'(s_wd), 32'(e_wd));
            chk("rnd_rdv", 32'(s_rdv), 32'(m_rdv));
            if (m_rdv != 3'b000) chk("rnd_rdata", 32'(s_rdd), 32'(m_rdd));
            if (acc && !req_wren[o]) begin
                m_rdv = e_gnt;
                m_rdd = mm[e_addr];
            end else begin
                m_rdv = 3'b000;
            end
            if (e_wr) mm[e_addr] = e_wd;
            if (granted) begin
                others = req & ~e_gnt;
                if (!req[o] || (others != 3'b000 && m_hold + 1 >= MH)) begin
                    m_last = o;
                    m_own  = -1;
                    m_turn = 1'b1;
                end else if (m_hold < MH) begin
                    m_hold++;
                end
            end else begin
                keep = req & ~3'(1 << m_last);
                cand = (m_turn && keep != 3'b000) ? keep : req;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                w = pick(cand, m_rr);
`else
                w = pick(cand, 0);
`endif
                m_turn = 1'b0;
                if (w >= 0) begin
                    m_own  = w;
                    m_hold = 0;
                    m_rr   = (w + 1) % N;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
